inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 161 ++++++++++++++++
 tb/tb_inst_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: assembles a byte stream into big-endian 16-bit instruction words
// and writes them into instruction memory starting at LOAD_BASE.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, len            load request and word count (len sampled on accepted start)
//   byte_in, byte_valid   incoming byte stream
//   byte_ready            loader can accept a byte this cycle (HI/LO states)
//   mem_addr, mem_wdata   instruction-memory write address / data
//   mem_we                one-cycle write strobe
//   busy, done, exc       load in progress, completion pulse, sticky out-of-range flag
//   word_count            words written in the current or most recent load
module inst_loader #(
  parameter int unsigned INSTR_ADDR_WIDTH     = 16,
  parameter int unsigned INSTR_DATA_BIT_WIDTH = 16,
  parameter int unsigned INSTR_MEM_SIZE       = 64,
  parameter int unsigned LOAD_BASE            = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_ADDR_WIDTH-1:0]     len,
  input  logic [7:0]                      byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  output logic [INSTR_ADDR_WIDTH-1:0]     mem_addr,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] mem_wdata,
  output logic                            mem_we,
  output logic                            busy,
  output logic                            done,
  output logic                            exc,
  output logic [INSTR_ADDR_WIDTH-1:0]     word_count
);

  localparam int unsigned AW    = INSTR_ADDR_WIDTH;
  localparam int unsigned DW    = INSTR_DATA_BIT_WIDTH;
  localparam int unsigned CMP_W = (AW > 32) ? AW : 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   len_q, len_d;
  logic            byte_ready_q, byte_ready_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            exc_q, exc_d;
  logic [AW-1:0]   word_count_q, word_count_d;

  logic            xfer_c;
  logic [AW-1:0]   addr_c;
  logic            in_range_c;
  logic [AW-1:0]   wc_inc_c;
  logic            last_c;

  // Handshake and target address for the word currently being assembled.
  assign xfer_c     = byte_valid & byte_ready_q;
  assign addr_c     = AW'(LOAD_BASE) + word_count_q;
  assign in_range_c = CMP_W'(addr_c) < CMP_W'(INSTR_MEM_SIZE);
  assign wc_inc_c   = word_count_q + AW'(1);
  assign last_c     = (wc_inc_c == len_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    exc_d        = exc_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          len_d        = len;
          word_count_d = '0;
          exc_d        = 1'b0;
          state_d      = (len == '0) ? S_DONE : S_HI;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_HI: begin
        if (xfer_c) begin
          mem_wdata_d[DW-1 -: 8] = byte_in;
          state_d                = S_LO;
        end
      end
      S_LO: begin
        // Strobe is raised together with entry to WRITE only if the target is in range.
        if (xfer_c) begin
          mem_wdata_d[7:0] = byte_in;
          mem_addr_d       = addr_c;
          mem_we_d         = in_range_c;
          state_d          = S_WRITE;
        end
      end
      S_WRITE: begin
        if (in_range_c) begin
          word_count_d = wc_inc_c;
          state_d      = last_c ? S_DONE : S_HI;
        end else begin
          exc_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    byte_ready_d = (state_d == S_HI) || (state_d == S_LO);
    busy_d       = byte_ready_d || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      exc_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_ready_q <= byte_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      exc_q        <= exc_d;
      word_count_q <= word_count_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign exc        = exc_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: table-driven loads on a LOAD_BASE=0 instance plus
// hand sequences for zero length, ignored start, mid-load reset and overflow
// (overflow uses a second instance with LOAD_BASE=62).
module tb_inst_loader;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start1;
  logic [AW-1:0] len;
  logic [7:0]    byte_in;
  logic          byte_valid;

  logic          byte_ready0, mem_we0, busy0, done0, exc0;
  logic [AW-1:0] mem_addr0, word_count0;
  logic [DW-1:0] mem_wdata0;
  logic          byte_ready1, mem_we1, busy1, done1, exc1;
  logic [AW-1:0] mem_addr1, word_count1;
  logic [DW-1:0] mem_wdata1;

  always #5 clk = ~clk;

  inst_loader #(.INSTR_ADDR_WIDTH(AW), .INSTR_DATA_BIT_WIDTH(DW),
                .INSTR_MEM_SIZE(64), .LOAD_BASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .len(len), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_we(mem_we0), .busy(busy0), .done(done0),
    .exc(exc0), .word_count(word_count0));

  inst_loader #(.INSTR_ADDR_WIDTH(AW), .INSTR_DATA_BIT_WIDTH(DW),
                .INSTR_MEM_SIZE(64), .LOAD_BASE(62)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .len(len), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .busy(busy1), .done(done1),
    .exc(exc1), .word_count(word_count1));

  // Write/done recorder; sole writer of these variables.
  logic [AW-1:0] wa0[64], wa1[64];
  logic [DW-1:0] wd0[64], wd1[64];
  int wn0 = 0, wn1 = 0, dn0 = 0, dn1 = 0;
  int bad_ready0 = 0, bad_ready1 = 0, bad_we0 = 0, bad_we1 = 0;
  logic pwe0 = 1'b0, pwe1 = 1'b0;

  always @(negedge clk) begin
    if (mem_we0) begin
      if (wn0 < 64) begin wa0[wn0] = mem_addr0; wd0[wn0] = mem_wdata0; end
      wn0++;
    end
    if (mem_we1) begin
      if (wn1 < 64) begin wa1[wn1] = mem_addr1; wd1[wn1] = mem_wdata1; end
      wn1++;
    end
    if (done0) dn0++;
    if (done1) dn1++;
    if (byte_ready0 && !busy0) bad_ready0++;
    if (byte_ready1 && !busy1) bad_ready1++;
    if (mem_we0 && pwe0) bad_we0++;
    if (mem_we1 && pwe1) bad_we1++;
    pwe0 = mem_we0;
    pwe1 = mem_we1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_load(input int which, input logic [AW-1:0] l);
    len = l;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Presents a byte (after gap idle cycles) and returns at the negedge following its transfer.
  task automatic send_byte(input int which, input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    byte_in    = 8'h5A;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while ((((which == 0) ? byte_ready0 : byte_ready1) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept_timeout", 64'(n < 40), 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'hA5;
  endtask

  typedef struct {
    logic [AW-1:0] len;
    logic [7:0]    b0, b1, b2, b3;
    int            gap;
    int            exp_n;
    logic [DW-1:0] exp_d0, exp_d1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bs[4];
    int bw, bd, gap;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; len = '0;
    byte_in = 8'h00; byte_valid = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("reset_outputs0", 64'({byte_ready0, mem_we0, busy0, done0, exc0, mem_addr0, mem_wdata0, word_count0}), 64'd0);
    chk("reset_outputs1", 64'({byte_ready1, mem_we1, busy1, done1, exc1, mem_addr1, mem_wdata1, word_count1}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{16'd2, 8'h12, 8'h34, 8'hAB, 8'hCD, 0, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{16'd2, 8'h12, 8'h34, 8'hAB, 8'hCD, 3, 2, 16'h1234, 16'hABCD};
    vecs[2] = '{16'd1, 8'h0F, 8'h0F, 8'h00, 8'h00, 0, 1, 16'h0F0F, 16'h0000};
    vecs[3] = '{16'd2, 8'hFF, 8'h00, 8'h00, 8'hFF, 2, 2, 16'hFF00, 16'h00FF};
    vecs[4] = '{16'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000};
    vecs[5] = '{16'd1, 8'h80, 8'h01, 8'h00, 8'h00, 1, 1, 16'h8001, 16'h0000};

    for (int i = 0; i < 6; i++) begin
      bw = wn0; bd = dn0;
      bs[0] = vecs[i].b0; bs[1] = vecs[i].b1; bs[2] = vecs[i].b2; bs[3] = vecs[i].b3;
      start_load(0, vecs[i].len);
      for (int w = 0; w < int'(vecs[i].len); w++) begin
        gap = (vecs[i].gap == 0) ? 0 : int'($urandom_range(vecs[i].gap, 1));
        send_byte(0, bs[2*w], gap);
        gap = (vecs[i].gap == 0) ? 0 : int'($urandom_range(vecs[i].gap, 1));
        send_byte(0, bs[2*w+1], gap);
      end
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_nwrites", i), 64'(wn0 - bw), 64'(vecs[i].exp_n));
      for (int j = 0; j < vecs[i].exp_n; j++) begin
        chk($sformatf("v%0d_addr%0d", i, j), 64'(wa0[bw+j]), 64'(j));
        chk($sformatf("v%0d_data%0d", i, j), 64'(wd0[bw+j]),
            64'((j == 0) ? vecs[i].exp_d0 : vecs[i].exp_d1));
      end
      chk($sformatf("v%0d_done", i), 64'(dn0 - bd), 64'd1);
      chk($sformatf("v%0d_word_count", i), 64'(word_count0), 64'(vecs[i].len));
      chk($sformatf("v%0d_exc", i), 64'(exc0), 64'd0);
      chk($sformatf("v%0d_busy", i), 64'(busy0), 64'd0);
    end

    // Zero length: done on the very next cycle, never ready.
    bw = wn0;
    start_load(0, 16'd0);
    chk("zero_done_next", 64'(done0), 64'd1);
    chk("zero_ready", 64'(byte_ready0), 64'd0);
    @(negedge clk);
    chk("zero_done_one_cycle", 64'(done0), 64'd0);
    chk("zero_no_write", 64'(wn0 - bw), 64'd0);

    // Start while busy is ignored; also check write latency after the low byte.
    bw = wn0; bd = dn0;
    start_load(0, 16'd2);
    send_byte(0, 8'h12, 0);
    len = 16'd9; start0 = 1'b1;
    send_byte(0, 8'h34, 0);
    start0 = 1'b0;
    chk("lat_we", 64'(mem_we0), 64'd1);
    chk("lat_addr", 64'(mem_addr0), 64'd0);
    chk("lat_data", 64'(mem_wdata0), 64'h1234);
    @(negedge clk);
    chk("we_drop", 64'(mem_we0), 64'd0);
    chk("wc_after_write", 64'(word_count0), 64'd1);
    len = 16'd9; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    send_byte(0, 8'hAB, 0);
    send_byte(0, 8'hCD, 0);
    repeat (6) @(negedge clk);
    chk("ign_nwrites", 64'(wn0 - bw), 64'd2);
    chk("ign_data1", 64'({wa0[bw+1], wd0[bw+1]}), 64'h0001_ABCD);
    chk("ign_done", 64'(dn0 - bd), 64'd1);
    chk("ign_word_count", 64'(word_count0), 64'd2);

    // Reset after the high byte of the second word.
    bw = wn0;
    start_load(0, 16'd2);
    send_byte(0, 8'h12, 0);
    send_byte(0, 8'h34, 0);
    send_byte(0, 8'hAB, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({byte_ready0, mem_we0, busy0, done0, exc0, mem_addr0, mem_wdata0, word_count0}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle", 64'({busy0, byte_ready0}), 64'd0);
    chk("midrst_nwrites", 64'(wn0 - bw), 64'd1);
    bw = wn0; bd = dn0;
    start_load(0, 16'd1);
    send_byte(0, 8'h0F, 0);
    send_byte(0, 8'h0F, 0);
    repeat (4) @(negedge clk);
    chk("postrst_nwrites", 64'(wn0 - bw), 64'd1);
    chk("postrst_write", 64'({wa0[bw], wd0[bw]}), 64'h0000_0F0F);
    chk("postrst_done", 64'(dn0 - bd), 64'd1);

    // Overflow on the LOAD_BASE=62 instance.
    bw = wn1; bd = dn1;
    start_load(1, 16'd4);
    send_byte(1, 8'h11, 0); send_byte(1, 8'h22, 0);
    send_byte(1, 8'h33, 0); send_byte(1, 8'h44, 0);
    send_byte(1, 8'h55, 0); send_byte(1, 8'h66, 0);
    repeat (4) @(negedge clk);
    chk("ovf_nwrites", 64'(wn1 - bw), 64'd2);
    chk("ovf_write0", 64'({wa1[bw], wd1[bw]}), 64'h003E_1122);
    chk("ovf_write1", 64'({wa1[bw+1], wd1[bw+1]}), 64'h003F_3344);
    chk("ovf_exc", 64'(exc1), 64'd1);
    chk("ovf_busy_ready", 64'({busy1, byte_ready1}), 64'd0);
    chk("ovf_no_done", 64'(dn1 - bd), 64'd0);
    chk("ovf_word_count", 64'(word_count1), 64'd2);
    bw = wn1; bd = dn1;
    start_load(1, 16'd1);
    chk("ovf_exc_cleared", 64'(exc1), 64'd0);
    send_byte(1, 8'h77, 0);
    send_byte(1, 8'h88, 0);
    repeat (4) @(negedge clk);
    chk("ovf_retry_write", 64'({wa1[bw], wd1[bw]}), 64'h003E_7788);
    chk("ovf_retry_done", 64'(dn1 - bd), 64'd1);
    chk("ovf_retry_exc", 64'(exc1), 64'd0);
    chk("ovf_retry_wc", 64'(word_count1), 64'd1);

    chk("ready_outside_load0", 64'(bad_ready0), 64'd0);
    chk("ready_outside_load1", 64'(bad_ready1), 64'd0);
    chk("we_single_cycle0", 64'(bad_we0), 64'd0);
    chk("we_single_cycle1", 64'(bad_we1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
